// File: rtl/axis_pkt_len_tracker.sv
// Passive AXI-Stream packet length monitor: measures each packet's byte count
// and queues the lengths (with a saturation flag) on a valid/ready output.

module find_last_bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    // One-indexed position of the highest set bit; 0 when no bit is set
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bits[i]) count = CNT_W'(i + 1);
        end
    end

endmodule

module axis_pkt_len_tracker #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  axis_aclk,
    input  logic                  axis_resetn,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [LEN_WIDTH-1:0]  len_tdata,
    output logic                  len_sat,
    output logic                  len_tvalid,
    input  logic                  len_tready,
    output logic                  in_packet,
    output logic [7:0]            drop_count,
    output logic                  overflow
);

    localparam int FLB_W = $clog2(KEEP_WIDTH + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = LEN_WIDTH + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_params
        $error("axis_pkt_len_tracker: invalid parameter combination");
    end

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   acc;
    logic                   acc_sat;

    logic                   beat;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic [FLB_W-1:0]       last_cnt;
    logic [LEN_WIDTH-1:0]   base;
    logic                   base_sat;
    logic [SUM_W-1:0]       addend;
    logic [SUM_W-1:0]       sum;
    logic [LEN_WIDTH-1:0]   nxt_len;
    logic                   nxt_sat;

    logic [LEN_WIDTH-1:0]   mem_len [FIFO_DEPTH];
    logic                   mem_sat [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic [PTR_W:0]         count_next;

    find_last_bit #(
        .WIDTH (KEEP_WIDTH),
        .CNT_W (FLB_W)
    ) u_find_last_bit (
        .bits  (s_axis_tkeep),
        .count (last_cnt)
    );

    assign beat  = s_axis_tvalid & s_axis_tready;
    assign push  = beat & s_axis_tlast;
    assign pop   = len_tvalid & len_tready;
    assign full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign wr_en = push & (~full | pop);

    // A beat seen in IDLE starts a fresh packet, so ignore whatever acc holds
    always_comb begin
        base     = (state == IDLE) ? '0 : acc;
        base_sat = (state == IDLE) ? 1'b0 : acc_sat;
        addend   = s_axis_tlast ? SUM_W'(last_cnt) : SUM_W'(KEEP_WIDTH);
        sum      = {1'b0, base} + addend;
        if (sum[LEN_WIDTH]) begin
            nxt_len = '1;
            nxt_sat = 1'b1;
        end else begin
            nxt_len = sum[LEN_WIDTH-1:0];
            nxt_sat = base_sat;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state   <= IDLE;
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (beat) begin
            if (s_axis_tlast) begin
                state   <= IDLE;
                acc     <= '0;
                acc_sat <= 1'b0;
            end else begin
                state   <= IN_PKT;
                acc     <= nxt_len;
                acc_sat <= nxt_sat;
            end
        end
    end

    assign in_packet = (state == IN_PKT);

    always_comb begin
        case ({wr_en, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage is reset too so the head reads back as zero after reset
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_len[i] <= '0;
                mem_sat[i] <= 1'b0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            len_tvalid <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_len[wr_ptr] <= nxt_len;
                mem_sat[wr_ptr] <= nxt_sat;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            len_tvalid <= (count_next != '0);
            if (push && !wr_en) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign len_tdata = mem_len[rd_ptr];
    assign len_sat   = mem_sat[rd_ptr];

endmodule

// File: tb/tb_axis_pkt_len_tracker.sv
// Directed bench for axis_pkt_len_tracker: default instance plus a
// LEN_WIDTH=8 instance for the saturation cases.

module tb_axis_pkt_len_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst8_n;
    logic [31:0] tkeep;
    logic        tvalid;
    logic        tvalid8;
    logic        tready;
    logic        tlast;
    logic        len_tready;
    logic        len_tready8;

    logic [15:0] len_tdata;
    logic        len_sat;
    logic        len_tvalid;
    logic        in_packet;
    logic [7:0]  drop_count;
    logic        overflow;

    logic [7:0]  len8_tdata;
    logic        len8_sat;
    logic        len8_tvalid;
    logic        in_packet8;
    logic [7:0]  drop_count8;
    logic        overflow8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_pkt_len_tracker #(
        .DATA_WIDTH (256),
        .LEN_WIDTH  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .axis_aclk     (clk),
        .axis_resetn   (rst_n),
        .s_axis_tkeep  (tkeep),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .len_tdata     (len_tdata),
        .len_sat       (len_sat),
        .len_tvalid    (len_tvalid),
        .len_tready    (len_tready),
        .in_packet     (in_packet),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    axis_pkt_len_tracker #(
        .DATA_WIDTH (256),
        .LEN_WIDTH  (8),
        .FIFO_DEPTH (4)
    ) dut8 (
        .axis_aclk     (clk),
        .axis_resetn   (rst8_n),
        .s_axis_tkeep  (tkeep),
        .s_axis_tvalid (tvalid8),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .len_tdata     (len8_tdata),
        .len_sat       (len8_sat),
        .len_tvalid    (len8_tvalid),
        .len_tready    (len_tready8),
        .in_packet     (in_packet8),
        .drop_count    (drop_count8),
        .overflow      (overflow8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at posedge+1; presents one beat and returns at posedge+1 after it is taken
    task automatic send(input logic [31:0] keep, input logic last, input logic sel8);
        tkeep  = keep;
        tlast  = last;
        tready = 1'b1;
        if (sel8) tvalid8 = 1'b1;
        else      tvalid  = 1'b1;
        @(posedge clk); #1;
        tvalid  = 1'b0;
        tvalid8 = 1'b0;
        tlast   = 1'b0;
        tkeep   = '0;
    endtask

    initial begin
        int exp_q[4];
        exp_q = '{32, 32, 32, 1};

        rst_n = 1'b0; rst8_n = 1'b0;
        tkeep = '0; tvalid = 1'b0; tvalid8 = 1'b0; tready = 1'b1; tlast = 1'b0;
        len_tready = 1'b0; len_tready8 = 1'b0;

        #3;
        check("rst_valid", len_tvalid, 0);
        check("rst_data", len_tdata, 0);
        check("rst_sat", len_sat, 0);
        check("rst_inpkt", in_packet, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;

        // single-beat packet
        len_tready = 1'b1;
        check("t1_pre_valid", len_tvalid, 0);
        send(32'h0000_00FF, 1'b1, 1'b0);
        check("t1_inpkt", in_packet, 0);
        check("t1_valid", len_tvalid, 1);
        check("t1_data", len_tdata, 8);
        check("t1_sat", len_sat, 0);
        @(posedge clk); #1;
        check("t1_popped", len_tvalid, 0);

        // tkeep with holes: only the highest set bit counts
        send(32'h0001_0001, 1'b1, 1'b0);
        check("hole_data", len_tdata, 17);
        @(posedge clk); #1;

        // three beats, middle beat stalled two cycles
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        check("t2_inpkt_b1", in_packet, 1);
        tkeep = 32'hFFFF_FFFF; tvalid = 1'b1; tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t2_inpkt_stall", in_packet, 1);
        check("t2_stall_valid", len_tvalid, 0);
        tready = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        send(32'h0000_FFFF, 1'b1, 1'b0);
        check("t2_inpkt_end", in_packet, 0);
        check("t2_valid", len_tvalid, 1);
        check("t2_data", len_tdata, 80);
        @(posedge clk); #1;

        // last beat with tkeep=0 adds nothing
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b1, 1'b0);
        check("zkeep_data", len_tdata, 32);
        @(posedge clk); #1;

        // five packets into a 4-deep FIFO with no consumer
        len_tready = 1'b0;
        repeat (5) send(32'hFFFF_FFFF, 1'b1, 1'b0);
        check("t3_drop", drop_count, 1);
        check("t3_ovf", overflow, 1);
        check("t3_valid", len_tvalid, 1);
        check("t3_data", len_tdata, 32);
        @(posedge clk); #1;
        check("t3_hold", len_tdata, 32);

        // full FIFO, pop and push in the same cycle
        len_tready = 1'b1;
        send(32'h0000_0001, 1'b1, 1'b0);
        check("t4_drop", drop_count, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), len_tvalid, 1);
            check($sformatf("drain_data%0d", i), len_tdata, exp_q[i]);
            @(posedge clk); #1;
        end
        check("drain_empty", len_tvalid, 0);

        // LEN_WIDTH=8 saturation
        repeat (8) send(32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 1'b1, 1'b1);
        check("t5_valid", len8_tvalid, 1);
        check("t5_data", len8_tdata, 255);
        check("t5_sat", len8_sat, 1);
        len_tready8 = 1'b1;
        send(32'h0000_0003, 1'b1, 1'b1);
        check("t5_next_data", len8_tdata, 2);
        check("t5_next_sat", len8_sat, 0);

        // asynchronous reset mid-packet with entries queued
        len_tready = 1'b0;
        send(32'h0000_00FF, 1'b1, 1'b0);
        send(32'h0000_000F, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        check("t6_pre_inpkt", in_packet, 1);
        check("t6_pre_data", len_tdata, 8);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", len_tvalid, 0);
        check("t6_data", len_tdata, 0);
        check("t6_sat", len_sat, 0);
        check("t6_inpkt", in_packet, 0);
        check("t6_drop", drop_count, 0);
        check("t6_ovf", overflow, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        len_tready = 1'b1;
        send(32'h0000_000F, 1'b1, 1'b0);
        check("t6_post_valid", len_tvalid, 1);
        check("t6_post_data", len_tdata, 4);
        check("t6_post_inpkt", in_packet, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
